// File: rtl/if_stage_hazard.sv
// Instruction-fetch front end: PC and IF/ID registers, load-use detection,
// MEM-resolved redirect with wrong-path squash, and saturating perf counters.
module if_stage_hazard #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [31:0]          pc_o,
    input  logic [31:0]          instruction_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    input  logic                 hold_i,
    input  logic                 ex_mem_read_i,
    input  logic [4:0]           ex_rt_i,
    output logic [31:0]          id_instruction_o,
    output logic [31:0]          id_pc_plus_4_o,
    output logic                 id_valid_o,
    output logic                 id_ex_bubble_o,
    output logic                 ex_mem_flush_o,
    output logic                 load_use_o,
    output logic                 misaligned_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    logic [31:0]          r_pc;
    logic [31:0]          r_id_instr;
    logic [31:0]          r_id_pc4;
    logic                 r_id_valid;
    logic                 r_misaligned;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic [31:0] w_pc_plus_4;
    logic [4:0]  w_id_rs;
    logic [4:0]  w_id_rt;
    logic        w_load_use;
    logic        w_stall_sat;
    logic        w_flush_sat;

    assign w_pc_plus_4 = r_pc + 32'd4;
    assign w_id_rs     = r_id_instr[25:21];
    assign w_id_rt     = r_id_instr[20:16];
    assign w_stall_sat = (r_stall_cnt == '1);
    assign w_flush_sat = (r_flush_cnt == '1);

    always_comb begin
        w_load_use     = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (!reset) begin
            w_load_use = ex_mem_read_i && r_id_valid && (ex_rt_i != 5'd0) &&
                         ((ex_rt_i == w_id_rs) || (ex_rt_i == w_id_rt));
            id_ex_bubble_o = redirect_i || hold_i || w_load_use;
            ex_mem_flush_o = redirect_i;
        end
    end

    // Priority: redirect squashes regardless of hold/stall; hold freezes without counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_id_instr   <= '0;
            r_id_pc4     <= '0;
            r_id_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else if (redirect_i) begin
            r_pc       <= {redirect_pc_i[31:2], 2'b00};
            r_id_instr <= '0;
            r_id_pc4   <= '0;
            r_id_valid <= 1'b0;
            if (!w_flush_sat)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (redirect_pc_i[1:0] != 2'b00)
                r_misaligned <= 1'b1;
        end else if (hold_i) begin
            r_pc <= r_pc;
        end else if (w_load_use) begin
            if (!w_stall_sat)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_pc       <= w_pc_plus_4;
            r_id_instr <= instruction_i;
            r_id_pc4   <= w_pc_plus_4;
            r_id_valid <= 1'b1;
        end
    end

    assign pc_o             = r_pc;
    assign id_instruction_o = r_id_instr;
    assign id_pc_plus_4_o   = r_id_pc4;
    assign id_valid_o       = r_id_valid;
    assign load_use_o       = w_load_use;
    assign misaligned_o     = r_misaligned;
    assign stall_cnt_o      = r_stall_cnt;
    assign flush_cnt_o      = r_flush_cnt;

endmodule
